// File: rtl/right_shift_rotate_seq_16bit_pkg.sv
// Shared definitions for the multi-cycle right shift/rotate unit.
// Contents: data/amount widths, mode codes and FSM state encoding.
// Optional feature macro RSR_ARITH_EN (used by right_step_16bit) enables
// sign-filling arithmetic right shift for mode 2'b10.
package right_shift_rotate_seq_16bit_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    // Mode codes; 2'b11 is not named and decodes as rotate.
    localparam logic [1:0] RSR_ROR = 2'b00;
    localparam logic [1:0] RSR_LSR = 2'b01;
    localparam logic [1:0] RSR_ASR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/right_step_16bit.sv
// Combinational single-position right step.
// Ports:
//   in   [15:0]  value to step
//   mode [1:0]   00/11 rotate right, 01 logical right, 10 arithmetic right
//   out  [15:0]  value moved right by one position
// Macro RSR_ARITH_EN: when defined, mode 10 fills with the sign bit; when
// undefined, mode 10 zero-fills and no sign-fill path exists.
module right_step_16bit
    import right_shift_rotate_seq_16bit_pkg::*;
(
    input  logic [15:0] in,
    input  logic [1:0]  mode,
    output logic [15:0] out
);

    // Select the fill bit entering position 15 according to the mode.
    always_comb begin
        out = {in[0], in[15:1]};
        case (mode)
            RSR_ROR: out = {in[0], in[15:1]};
            RSR_LSR: out = {1'b0, in[15:1]};
`ifdef RSR_ARITH_EN
            RSR_ASR: out = {in[15], in[15:1]};
`else
            RSR_ASR: out = {1'b0, in[15:1]};
`endif
            default: out = {in[0], in[15:1]};
        endcase
    end

endmodule

// File: rtl/right_shift_rotate_seq_16bit.sv
// Multi-cycle 16-bit right shift/rotate unit, one bit position per clock.
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  operand handshake (in_ready high only when idle)
//   in, shift, mode    operand, amount 0..15, mode (00/11 ror, 01 lsr, 10 asr)
//   out_valid/out_ready result handshake (out_valid high only when done)
//   out                result register
//   busy               high while shifting or holding a result
// Macro RSR_ARITH_EN selects sign-fill for mode 10 (see right_step_16bit).
module right_shift_rotate_seq_16bit
    import right_shift_rotate_seq_16bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] shift,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [1:0]       mode_r;
    logic [WIDTH-1:0] out_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [WIDTH-1:0] step_s;

    right_step_16bit u_step (
        .in   (out_r),
        .mode (mode_r),
        .out  (step_s)
    );

    // Control FSM with datapath registers; handshake flags are registered
    // alongside the state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            count_r     <= {CNT_W{1'b0}};
            mode_r      <= 2'b00;
            out_r       <= {WIDTH{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // in_ready is high in IDLE, so in_valid alone is an accept.
                    if (in_valid) begin
                        out_r      <= in;
                        count_r    <= shift;
                        mode_r     <= mode;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (shift == {CNT_W{1'b0}}) begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r     <= ST_SHIFT;
                            out_valid_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    out_r   <= step_s;
                    count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    // count==1 means this edge performs the final step.
                    if (count_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    count_r     <= {CNT_W{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out       = out_r;

endmodule
